// File: rtl/vga_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl_if
//  Output bundle of the VGA scan controller: the pixel strobe, sync pulses and
//  the read coordinates used to address the 120x120 video memory.
//   oPixelTick   one-clock strobe per pixel period
//   oHSync       horizontal sync, active low
//   oVSync       vertical sync, active low
//   oVideoOn     current pixel lies inside the displayed memory window
//   oVideoMemX   memory read column
//   oVideoMemY   memory read row
//   oFrameStart  one-pixel pulse at the frame boundary
//  master: the scan controller (drives everything)
//  slave : video memory / colour mux / VGA pins (observe everything)
// ---------------------------------------------------------------------------
interface vga_scan_ctrl_if;
    logic       oPixelTick;
    logic       oHSync;
    logic       oVSync;
    logic       oVideoOn;
    logic [6:0] oVideoMemX;
    logic [6:0] oVideoMemY;
    logic       oFrameStart;

    modport master (
        output oPixelTick,
        output oHSync,
        output oVSync,
        output oVideoOn,
        output oVideoMemX,
        output oVideoMemY,
        output oFrameStart
    );

    modport slave (
        input oPixelTick,
        input oHSync,
        input oVSync,
        input oVideoOn,
        input oVideoMemX,
        input oVideoMemY,
        input oFrameStart
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// ---------------------------------------------------------------------------
// vga_scan_ctrl
//  Read-side controller for the video memory. Generates 640x480@60 VGA timing
//  and the memory read coordinates for a MEM_WIDTH_X x MEM_WIDTH_Y pixel store,
//  each memory pixel drawn as a SCALE x SCALE screen block, window starting at
//  column H_OFFSET.
//  Ports:
//   iClk    system clock (CLK_DIV clocks per pixel)
//   iReset  synchronous reset, active high
//   vga     vga_scan_ctrl_if.master: tick, syncs, video-on, memory X/Y,
//           frame-start pulse
//  Timing: oPixelTick is high for one iClk cycle per pixel. On the clock edge
//  that ends a tick cycle, every other output is loaded from the (hcount,
//  vcount) pair being presented and the counters advance. The memory read is
//  combinational, so colour lines up with the syncs and oVideoOn with no
//  extra delay. The colour mux downstream must force black when oVideoOn=0.
// ---------------------------------------------------------------------------
module vga_scan_ctrl #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int MEM_WIDTH_X = 120,
    parameter int MEM_WIDTH_Y = 120,
    parameter int SCALE       = 4,
    parameter int H_OFFSET    = 80,
    parameter int CLK_DIV     = 2
) (
    input  logic            iClk,
    input  logic            iReset,
    vga_scan_ctrl_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] WIN_X0   = HW'(H_OFFSET);
    localparam logic [HW-1:0] WIN_X1   = HW'(H_OFFSET + SCALE * MEM_WIDTH_X);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] WIN_Y1   = VW'(SCALE * MEM_WIDTH_Y);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [6:0]    X_LAST   = 7'(MEM_WIDTH_X - 1);
    localparam logic [6:0]    Y_LAST   = 7'(MEM_WIDTH_Y - 1);

    // Timing counters
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Coordinate generators: x_q/y_q hold the coordinate for the pixel/line
    // about to be presented, xsub_q/ysub_q count screen pixels/lines within
    // the current memory pixel.
    logic [SW-1:0] xsub_q, xsub_d;
    logic [6:0]    x_q, x_d;
    logic [SW-1:0] ysub_q, ysub_d;
    logic [6:0]    y_q, y_d;

    // Registered outputs
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          on_q, on_d;
    logic [6:0]    memx_q, memx_d;
    logic [6:0]    memy_q, memy_d;
    logic          fs_q, fs_d;

    logic          in_win;

    assign in_win = (h_q >= WIN_X0) && (h_q < WIN_X1) && (v_q < WIN_Y1);

    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        // Registered strobe: high for the single cycle after the divider
        // reaches its last count.
        tick_d  = (div_q == DIV_LAST);
        h_d     = h_q;
        v_d     = v_q;
        xsub_d  = xsub_q;
        x_d     = x_q;
        ysub_d  = ysub_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        on_d    = on_q;
        memx_d  = memx_q;
        memy_d  = memy_q;
        fs_d    = fs_q;

        if (tick_q) begin
            hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
            vsync_d = !((v_q >= VS_START) && (v_q < VS_END));
            on_d    = in_win;
            fs_d    = (h_q == '0) && (v_q == '0);
            memy_d  = y_q;

            if (in_win) begin
                memx_d = x_q;
                if (xsub_q == SUB_LAST) begin
                    xsub_d = '0;
                    // Saturate on the last memory column instead of wrapping.
                    if (x_q != X_LAST) begin
                        x_d = x_q + 7'd1;
                    end
                end else begin
                    xsub_d = xsub_q + SW'(1);
                end
            end else begin
                // Outside the window X reads as 0; this also re-arms the
                // column generator before the next line's window.
                memx_d = '0;
                x_d    = '0;
                xsub_d = '0;
            end

            if (h_q == H_LAST) begin
                h_d = '0;
                // Row generator steps at the end of each visible line and
                // saturates on the last memory row.
                if (v_q < V_VIS) begin
                    if (ysub_q == SUB_LAST) begin
                        ysub_d = '0;
                        if (y_q != Y_LAST) begin
                            y_d = y_q + 7'd1;
                        end
                    end else begin
                        ysub_d = ysub_q + SW'(1);
                    end
                end
                if (v_q == V_LAST) begin
                    v_d    = '0;
                    y_d    = '0;
                    ysub_d = '0;
                end else begin
                    v_d = v_q + VW'(1);
                end
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            xsub_q  <= '0;
            x_q     <= '0;
            ysub_q  <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            on_q    <= 1'b0;
            memx_q  <= '0;
            memy_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            h_q     <= h_d;
            v_q     <= v_d;
            xsub_q  <= xsub_d;
            x_q     <= x_d;
            ysub_q  <= ysub_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            on_q    <= on_d;
            memx_q  <= memx_d;
            memy_q  <= memy_d;
            fs_q    <= fs_d;
        end
    end

    assign vga.oPixelTick  = tick_q;
    assign vga.oHSync      = hsync_q;
    assign vga.oVSync      = vsync_q;
    assign vga.oVideoOn    = on_q;
    assign vga.oVideoMemX  = memx_q;
    assign vga.oVideoMemY  = memy_q;
    assign vga.oFrameStart = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Testbench for vga_scan_ctrl. Horizontal timing is the real 800-pixel line;
// the vertical dimension is shrunk (18-line frame, 3-row memory) so several
// whole frames fit in a short run.
module tb_vga_scan_ctrl;

    localparam int H_VISIBLE   = 640;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BACK      = 48;
    localparam int V_VISIBLE   = 12;
    localparam int V_FRONT     = 2;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 2;
    localparam int MEM_WIDTH_X = 120;
    localparam int MEM_WIDTH_Y = 3;
    localparam int SCALE       = 4;
    localparam int H_OFFSET    = 80;
    localparam int CLK_DIV     = 2;
    localparam int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam longint FRAME   = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_scan_ctrl_if vif ();

    vga_scan_ctrl #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .MEM_WIDTH_X(MEM_WIDTH_X), .MEM_WIDTH_Y(MEM_WIDTH_Y), .SCALE(SCALE),
        .H_OFFSET(H_OFFSET), .CLK_DIV(CLK_DIV)
    ) dut (
        .iClk  (clk),
        .iReset(rst),
        .vga   (vif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clocks elapsed since the last reset edge fully
    // determine every output.
    longint c     = 0;
    bit     valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            c     <= 0;
            valid <= 1'b1;
        end else begin
            c <= c + 1;
        end
    end

    // Expected outputs while pixel p (counted from the frame start) is shown.
    function automatic void model(input longint p, output logic hs, output logic vs,
                                  output logic on, output logic fs,
                                  output int x, output int y);
        int h;
        int v;
        int yv;
        h  = int'(p % H_TOTAL);
        v  = int'((p / H_TOTAL) % V_TOTAL);
        hs = !(h >= H_VISIBLE + H_FRONT && h < H_VISIBLE + H_FRONT + H_SYNC);
        vs = !(v >= V_VISIBLE + V_FRONT && v < V_VISIBLE + V_FRONT + V_SYNC);
        on = (h >= H_OFFSET) && (h < H_OFFSET + SCALE * MEM_WIDTH_X) && (v < SCALE * MEM_WIDTH_Y);
        fs = (p % FRAME) == 0;
        x  = on ? (h - H_OFFSET) / SCALE : 0;
        if (x > MEM_WIDTH_X - 1) x = MEM_WIDTH_X - 1;
        yv = (v < V_VISIBLE) ? v : V_VISIBLE - 1;
        y  = yv / SCALE;
        if (y > MEM_WIDTH_Y - 1) y = MEM_WIDTH_Y - 1;
    endfunction

    always @(negedge clk) begin
        logic e_hs, e_vs, e_on, e_fs, e_tick;
        int   e_x, e_y;
        if (valid) begin
            e_tick = (c >= 2) && (c % 2 == 0);
            if (c >= 3) begin
                model((c - 3) / 2, e_hs, e_vs, e_on, e_fs, e_x, e_y);
            end else begin
                e_hs = 1'b1; e_vs = 1'b1; e_on = 1'b0; e_fs = 1'b0; e_x = 0; e_y = 0;
            end
            check("tick",  32'(vif.oPixelTick),  32'(e_tick));
            check("hsync", 32'(vif.oHSync),      32'(e_hs));
            check("vsync", 32'(vif.oVSync),      32'(e_vs));
            check("on",    32'(vif.oVideoOn),    32'(e_on));
            check("fs",    32'(vif.oFrameStart), 32'(e_fs));
            check("memx",  32'(vif.oVideoMemX),  32'(e_x));
            check("memy",  32'(vif.oVideoMemY),  32'(e_y));
        end
    end

    int first_tick, hs_fall0, hs_fall1, hs_rise0, fs_rise0, fs_rise1, on_rise;
    int on_cycles, vs_low, maxx, maxy, n, len, rlen;
    logic prev_hs, prev_fs, prev_on;

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // Free-running frame: pin the model with hand-computed figures.
        first_tick = -1; hs_fall0 = -1; hs_fall1 = -1; hs_rise0 = -1;
        fs_rise0 = -1; fs_rise1 = -1; on_rise = -1;
        on_cycles = 0; vs_low = 0; maxx = 0; maxy = 0;
        prev_hs = 1'b1; prev_fs = 1'b0; prev_on = 1'b0;
        for (int i = 1; i <= 29000; i++) begin
            @(negedge clk);
            if (vif.oPixelTick === 1'b1 && first_tick < 0) first_tick = i;
            if (vif.oHSync === 1'b0 && prev_hs === 1'b1) begin
                if (hs_fall0 < 0) hs_fall0 = i;
                else if (hs_fall1 < 0) hs_fall1 = i;
            end
            if (vif.oHSync === 1'b1 && prev_hs === 1'b0 && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = i;
            if (vif.oFrameStart === 1'b1 && prev_fs === 1'b0) begin
                if (fs_rise0 < 0) fs_rise0 = i;
                else if (fs_rise1 < 0) fs_rise1 = i;
            end
            if (vif.oVideoOn === 1'b1 && prev_on === 1'b0 && on_rise < 0) on_rise = i;
            if (i < 3 + 2 * int'(FRAME)) begin
                if (vif.oVideoOn === 1'b1) on_cycles++;
                if (vif.oVSync === 1'b0) vs_low++;
            end
            if (int'(vif.oVideoMemX) > maxx) maxx = int'(vif.oVideoMemX);
            if (int'(vif.oVideoMemY) > maxy) maxy = int'(vif.oVideoMemY);
            prev_hs = vif.oHSync; prev_fs = vif.oFrameStart; prev_on = vif.oVideoOn;
        end
        check("first_tick_cycle", 32'(first_tick), 32'd2);
        check("first_frame_start", 32'(fs_rise0), 32'd3);
        check("on_rise_cycle", 32'(on_rise), 32'd163);          // 3 + 2*80
        check("line_period", 32'(hs_fall1 - hs_fall0), 32'd1600);
        check("hsync_width", 32'(hs_rise0 - hs_fall0), 32'd192); // 96 ticks
        check("frame_period", 32'(fs_rise1 - fs_rise0), 32'd28800);
        check("on_cycles_frame", 32'(on_cycles), 32'd11520);    // 480*12*2
        check("vsync_low_cycles", 32'(vs_low), 32'd3200);       // 2 lines
        check("max_memx", 32'(maxx), 32'd119);
        check("max_memy", 32'(maxy), 32'd2);

        // Mid-frame reset at hcount=300, vcount=5.
        n = 0;
        while (!(c >= 3 && ((c - 3) / 2) % FRAME == 5 * H_TOTAL + 300) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("reach_mid_frame", 32'(n < 40000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_hsync", 32'(vif.oHSync), 32'd1);
        check("reset_vsync", 32'(vif.oVSync), 32'd1);
        fs_rise0 = -1; fs_rise1 = -1; prev_fs = 1'b0;
        for (int i = 1; i <= 29000; i++) begin
            @(negedge clk);
            if (vif.oFrameStart === 1'b1 && prev_fs === 1'b0) begin
                if (fs_rise0 < 0) fs_rise0 = i;
                else if (fs_rise1 < 0) fs_rise1 = i;
            end
            prev_fs = vif.oFrameStart;
        end
        check("restart_frame_start", 32'(fs_rise0), 32'd3);
        check("restart_next_frame", 32'(fs_rise1), 32'd28803);

        // Random reset pulses at random points in the scan.
        for (int k = 0; k < 4; k++) begin
            len  = int'($urandom_range(50, 3000));
            rlen = int'($urandom_range(1, 4));
            repeat (len) @(negedge clk);
            rst = 1'b1;
            repeat (rlen) @(negedge clk);
            rst = 1'b0;
        end
        repeat (2000) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
